// File: rtl/serdes_align_pkg.sv
// Shared types and helpers for the I_SERDES word aligner.
package serdes_align_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SEARCH  = 3'd1,
    ST_SLIP    = 3'd2,
    ST_SETTLE  = 3'd3,
    ST_CONFIRM = 3'd4,
    ST_LOCKED  = 3'd5,
    ST_FAIL    = 3'd6
  } align_state_t;

  localparam int unsigned MAX_WIDTH = 10;
  localparam logic [MAX_WIDTH-1:0] DEFAULT_TRAIN_PATTERN = 10'h3E0;

  // Rotate the low `width` bits of `word` left by `amount`, as a bitslip would.
  function automatic logic [MAX_WIDTH-1:0] rotl_word(input logic [MAX_WIDTH-1:0] word,
                                                     input int unsigned amount,
                                                     input int unsigned width);
    logic [MAX_WIDTH-1:0] mask;
    logic [MAX_WIDTH-1:0] r;
    mask = 10'h3FF >> (MAX_WIDTH - width);
    r = word & mask;
    for (int i = 0; i < int'(amount % width); i++) begin
      r = ((r << 1) | (r >> (width - 1))) & mask;
    end
    return r;
  endfunction

endpackage

// File: rtl/serdes_word_aligner.sv
// Drives I_SERDES BITSLIP_ADJ until the training pattern lines up, then
// reports alignment and, in training mode, re-acquires on sustained loss.
module serdes_word_aligner
  import serdes_align_pkg::*;
#(
  parameter int unsigned       WIDTH         = 10,
  parameter logic [WIDTH-1:0]  TRAIN_PATTERN = DEFAULT_TRAIN_PATTERN[WIDTH-1:0],
  parameter int unsigned       SLIP_SETTLE   = 4,
  parameter int unsigned       LOCK_COUNT    = 8,
  parameter int unsigned       UNLOCK_COUNT  = 4
) (
  input  logic                      fabric_clk_div,
  input  logic                      reset_buf_n,
  input  logic                      enable,
  input  logic                      train_mode,
  input  logic                      dpa_lock,
  input  logic                      data_valid,
  input  logic [WIDTH-1:0]          data_in,
  output logic                      bitslip_adj,
  output logic                      aligned,
  output logic [$clog2(WIDTH)-1:0]  slip_count,
  output logic                      align_error
);

  localparam int unsigned SCW = $clog2(WIDTH);
  localparam int unsigned AW  = $clog2(WIDTH + 1);
  localparam int unsigned MW  = $clog2(LOCK_COUNT + 1);
  localparam int unsigned UW  = $clog2(UNLOCK_COUNT + 1);
  localparam int unsigned SW  = $clog2(SLIP_SETTLE + 1);

  localparam logic [SCW-1:0] SLIP_MAX     = SCW'(WIDTH - 1);
  localparam logic [AW-1:0]  ATTEMPT_LAST = AW'(WIDTH - 1);
  localparam logic [MW-1:0]  MATCH_LAST   = MW'(LOCK_COUNT - 1);
  localparam logic [UW-1:0]  MISS_LAST    = UW'(UNLOCK_COUNT - 1);
  localparam logic [SW-1:0]  SETTLE_LAST  = SW'(SLIP_SETTLE - 1);

  align_state_t   state_r;
  logic [AW-1:0]  attempt_r;
  logic [MW-1:0]  match_r;
  logic [UW-1:0]  miss_r;
  logic [SW-1:0]  settle_r;
  logic           match_s;

  assign match_s = (data_in == TRAIN_PATTERN);

  // Alignment FSM; every output is a register written here.
  always_ff @(posedge fabric_clk_div or negedge reset_buf_n) begin
    if (!reset_buf_n) begin
      state_r     <= ST_IDLE;
      attempt_r   <= {AW{1'b0}};
      match_r     <= {MW{1'b0}};
      miss_r      <= {UW{1'b0}};
      settle_r    <= {SW{1'b0}};
      bitslip_adj <= 1'b0;
      aligned     <= 1'b0;
      slip_count  <= {SCW{1'b0}};
      align_error <= 1'b0;
    end else if (!enable || !dpa_lock) begin
      // Loss of enable or DPA lock pre-empts everything; slip_count keeps
      // tracking the deserializer bit position.
      state_r     <= ST_IDLE;
      attempt_r   <= {AW{1'b0}};
      match_r     <= {MW{1'b0}};
      miss_r      <= {UW{1'b0}};
      settle_r    <= {SW{1'b0}};
      bitslip_adj <= 1'b0;
      aligned     <= 1'b0;
      if (!enable) begin
        align_error <= 1'b0;
      end
    end else begin
      bitslip_adj <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          aligned   <= 1'b0;
          attempt_r <= {AW{1'b0}};
          match_r   <= {MW{1'b0}};
          miss_r    <= {UW{1'b0}};
          state_r   <= ST_SEARCH;
        end
        ST_SEARCH: begin
          if (data_valid) begin
            if (!match_s) begin
              bitslip_adj <= 1'b1;
              state_r     <= ST_SLIP;
            end else if (LOCK_COUNT == 1) begin
              aligned   <= 1'b1;
              attempt_r <= {AW{1'b0}};
              miss_r    <= {UW{1'b0}};
              state_r   <= ST_LOCKED;
            end else begin
              match_r <= MW'(1);
              state_r <= ST_CONFIRM;
            end
          end
        end
        ST_SLIP: begin
          slip_count <= (slip_count == SLIP_MAX) ? {SCW{1'b0}} : slip_count + SCW'(1);
          attempt_r  <= attempt_r + AW'(1);
          settle_r   <= {SW{1'b0}};
          if (attempt_r == ATTEMPT_LAST) begin
            align_error <= 1'b1;
            state_r     <= ST_FAIL;
          end else begin
            state_r <= ST_SETTLE;
          end
        end
        ST_SETTLE: begin
          if (data_valid) begin
            if (settle_r == SETTLE_LAST) begin
              settle_r <= {SW{1'b0}};
              state_r  <= ST_SEARCH;
            end else begin
              settle_r <= settle_r + SW'(1);
            end
          end
        end
        ST_CONFIRM: begin
          if (data_valid) begin
            if (!match_s) begin
              match_r     <= {MW{1'b0}};
              bitslip_adj <= 1'b1;
              state_r     <= ST_SLIP;
            end else if (match_r == MATCH_LAST) begin
              match_r   <= {MW{1'b0}};
              aligned   <= 1'b1;
              attempt_r <= {AW{1'b0}};
              miss_r    <= {UW{1'b0}};
              state_r   <= ST_LOCKED;
            end else begin
              match_r <= match_r + MW'(1);
            end
          end
        end
        ST_LOCKED: begin
          // Payload mode cannot be compared against the pattern, so lock is held.
          if (!train_mode) begin
            miss_r <= {UW{1'b0}};
          end else if (data_valid) begin
            if (match_s) begin
              miss_r <= {UW{1'b0}};
            end else if (miss_r == MISS_LAST) begin
              miss_r  <= {UW{1'b0}};
              aligned <= 1'b0;
              state_r <= ST_SEARCH;
            end else begin
              miss_r <= miss_r + UW'(1);
            end
          end
        end
        ST_FAIL: begin
          align_error <= 1'b1;
        end
        default: begin
          aligned <= 1'b0;
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serdes_word_aligner.sv
// Directed bench for serdes_word_aligner with a rotating-word serdes model
// and a queue of expected results.
module tb_serdes_word_aligner;
  import serdes_align_pkg::*;

  localparam int unsigned W = 10;

  logic       fabric_clk_div = 1'b0;
  logic       reset_buf_n;
  logic       enable;
  logic       train_mode;
  logic       dpa_lock;
  logic       data_valid;
  logic [9:0] data_in;
  logic       bitslip_adj;
  logic       aligned;
  logic [3:0] slip_count;
  logic       align_error;

  always #5 fabric_clk_div = ~fabric_clk_div;

  serdes_word_aligner #(
    .WIDTH(W), .TRAIN_PATTERN(DEFAULT_TRAIN_PATTERN),
    .SLIP_SETTLE(4), .LOCK_COUNT(8), .UNLOCK_COUNT(4)
  ) dut (
    .fabric_clk_div(fabric_clk_div), .reset_buf_n(reset_buf_n),
    .enable(enable), .train_mode(train_mode), .dpa_lock(dpa_lock),
    .data_valid(data_valid), .data_in(data_in),
    .bitslip_adj(bitslip_adj), .aligned(aligned),
    .slip_count(slip_count), .align_error(align_error)
  );

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;

  exp_t        sb[$];
  int          checks_total  = 0;
  int          checks_passed = 0;
  int          checks_failed = 0;
  int unsigned rot           = 0;
  int unsigned pulses        = 0;
  int unsigned vw_since      = 0;
  int unsigned min_gap       = 1000;
  int unsigned cyc           = 0;
  int unsigned last_pulse_cyc = 0;
  int unsigned err_cyc       = 0;
  int unsigned double_pulse  = 0;
  logic        prev_slip     = 1'b0;

  task automatic expect_val(input string tag, input logic [31:0] val);
    exp_t e;
    e.tag = tag;
    e.val = val;
    sb.push_back(e);
  endtask

  task automatic check_next(input logic [31:0] obs);
    exp_t e;
    checks_total++;
    if (sb.size() == 0) begin
      checks_failed++;
      $error("FAIL scoreboard_empty observed=%0h required=none", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.val) checks_passed++;
      else begin
        checks_failed++;
        $error("FAIL %s observed=%0h required=%0h", e.tag, obs, e.val);
      end
    end
  endtask

  function automatic logic [9:0] model_word();
    return rotl_word(DEFAULT_TRAIN_PATTERN, rot, W);
  endfunction

  // One fabric cycle; a sampled pulse rotates the model serdes by one bit.
  task automatic cycle(input logic valid, input logic [9:0] word);
    data_valid = valid;
    data_in    = word;
    @(posedge fabric_clk_div);
    #1;
    cyc++;
    if (valid) vw_since++;
    if (bitslip_adj) begin
      if (prev_slip) double_pulse++;
      if (pulses > 0 && vw_since < min_gap) min_gap = vw_since;
      vw_since       = 0;
      pulses++;
      last_pulse_cyc = cyc;
      rot            = (rot + 1) % W;
    end
    prev_slip = bitslip_adj;
  endtask

  initial begin
    reset_buf_n = 1'b0;
    enable      = 1'b0;
    train_mode  = 1'b0;
    dpa_lock    = 1'b0;
    data_valid  = 1'b0;
    data_in     = 10'h000;
    repeat (3) @(posedge fabric_clk_div);
    #1;

    // Reset state
    expect_val("rst_bitslip", 32'd0);
    expect_val("rst_aligned", 32'd0);
    expect_val("rst_slip_count", 32'd0);
    expect_val("rst_align_error", 32'd0);
    check_next(bitslip_adj);
    check_next(aligned);
    check_next(slip_count);
    check_next(align_error);

    // 1: offset 0, one idle gap inside the run of matches
    reset_buf_n = 1'b1;
    enable      = 1'b1;
    dpa_lock    = 1'b1;
    train_mode  = 1'b1;
    rot         = 0;
    cycle(1'b0, 10'h000);
    repeat (4) cycle(1'b1, model_word());
    cycle(1'b0, 10'h155);
    repeat (3) cycle(1'b1, model_word());
    expect_val("t1_aligned_after_7", 32'd0);
    check_next(aligned);
    cycle(1'b1, model_word());
    expect_val("t1_aligned_after_8", 32'd1);
    expect_val("t1_pulses", 32'd0);
    expect_val("t1_slip_count", 32'd0);
    check_next(aligned);
    check_next(pulses);
    check_next(slip_count);

    // 2: offset 3
    enable = 1'b0;
    cycle(1'b0, 10'h000);
    rot = W - 3;
    pulses = 0;
    min_gap = 1000;
    vw_since = 0;
    enable = 1'b1;
    cycle(1'b0, 10'h000);
    expect_val("t2_aligned", 32'd1);
    expect_val("t2_pulses", 32'd3);
    expect_val("t2_gap_ok", 32'd1);
    expect_val("t2_words_after_last_slip", 32'd13);
    expect_val("t2_slip_count", 32'd3);
    for (int i = 0; i < 200 && aligned !== 1'b1; i++) cycle(1'b1, model_word());
    check_next(aligned);
    check_next(pulses);
    check_next(min_gap >= 5);
    check_next(vw_since);
    check_next(slip_count);

    // 3: pattern absent, starting from a cleared slip position
    reset_buf_n = 1'b0;
    #2;
    reset_buf_n = 1'b1;
    pulses = 0;
    min_gap = 1000;
    vw_since = 0;
    expect_val("t3_align_error", 32'd1);
    expect_val("t3_pulses", 32'd10);
    expect_val("t3_error_delay", 32'd1);
    expect_val("t3_slip_count_wrap", 32'd0);
    expect_val("t3_gap_ok", 32'd1);
    for (int i = 0; i < 300 && align_error !== 1'b1; i++) cycle(1'b1, 10'h155);
    err_cyc = cyc;
    check_next(align_error);
    check_next(pulses);
    check_next(err_cyc - last_pulse_cyc);
    check_next(slip_count);
    check_next(min_gap >= 5);
    repeat (30) cycle(1'b1, 10'h155);
    expect_val("t3_no_more_pulses", 32'd10);
    expect_val("t3_error_sticky", 32'd1);
    check_next(pulses);
    check_next(align_error);
    enable = 1'b0;
    cycle(1'b1, 10'h155);
    expect_val("t3_error_cleared", 32'd0);
    check_next(align_error);
    enable = 1'b1;
    pulses = 0;
    repeat (3) cycle(1'b1, 10'h155);
    expect_val("t3_restart_pulses", 32'd1);
    expect_val("t3_restart_slip_count", 32'd1);
    check_next(pulses);
    check_next(slip_count);

    // 4: loss-of-lock hysteresis in training mode, held lock in payload mode
    enable = 1'b0;
    cycle(1'b0, 10'h000);
    rot = 0;
    pulses = 0;
    enable = 1'b1;
    cycle(1'b0, 10'h000);
    repeat (8) cycle(1'b1, model_word());
    expect_val("t4_locked", 32'd1);
    check_next(aligned);
    for (int k = 0; k < 3; k++) begin
      cycle(1'b1, 10'h155);
      expect_val("t4_aligned_during_first_misses", 32'd1);
      check_next(aligned);
    end
    cycle(1'b1, model_word());
    repeat (3) cycle(1'b1, 10'h155);
    expect_val("t4_aligned_after_3_consecutive", 32'd1);
    check_next(aligned);
    cycle(1'b1, 10'h155);
    expect_val("t4_dropped_after_4th", 32'd0);
    check_next(aligned);
    for (int i = 0; i < 40 && aligned !== 1'b1; i++) cycle(1'b1, model_word());
    expect_val("t4_relocked", 32'd1);
    expect_val("t4_no_pulses", 32'd0);
    check_next(aligned);
    check_next(pulses);
    train_mode = 1'b0;
    repeat (6) cycle(1'b1, 10'h155);
    expect_val("t4_payload_holds_lock", 32'd1);
    check_next(aligned);

    // 5: dpa_lock drops on the same cycle as a mismatch in SEARCH
    train_mode = 1'b1;
    enable = 1'b0;
    cycle(1'b0, 10'h000);
    enable = 1'b1;
    cycle(1'b0, 10'h000);
    dpa_lock = 1'b0;
    cycle(1'b1, 10'h155);
    expect_val("t5_no_pulse", 32'd0);
    expect_val("t5_aligned", 32'd0);
    expect_val("t5_slip_count_kept", 32'd1);
    check_next(bitslip_adj);
    check_next(aligned);
    check_next(slip_count);
    dpa_lock = 1'b1;
    cycle(1'b1, 10'h155);
    expect_val("t5_idle_ignores_word", 32'd0);
    check_next(bitslip_adj);
    cycle(1'b1, 10'h155);
    expect_val("t5_search_then_pulse", 32'd1);
    check_next(bitslip_adj);

    // 6: asynchronous reset during the pulse
    reset_buf_n = 1'b0;
    #1;
    expect_val("t6_bitslip", 32'd0);
    expect_val("t6_aligned", 32'd0);
    expect_val("t6_slip_count", 32'd0);
    expect_val("t6_align_error", 32'd0);
    check_next(bitslip_adj);
    check_next(aligned);
    check_next(slip_count);
    check_next(align_error);

    expect_val("single_cycle_pulses", 32'd0);
    check_next(double_pulse);

    #20;
    reset_buf_n = 1'b1;
    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
